// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: hazard wait, operand forwarding, PC redirect/flush/stall.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic        ConditionD,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic [4:0]  WriteRegM,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        PCSrcD,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FlushD
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] BrCnt,
  output logic [31:0] TakenCnt,
  output logic [31:0] StallCycCnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RES} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       is_beq, is_bbt, is_br;
  logic [1:0] wait_rs, wait_rt, need;
  logic       fwd_a, fwd_b, resolve;

  assign is_beq = (OpD == 6'b000100);
  assign is_bbt = (OpD == 6'b111111);
  assign is_br  = is_beq | is_bbt;

  always_comb begin
    wait_rs = '0;
    if (RsD != '0 && RegWriteM && MemtoRegM && WriteRegM == RsD) wait_rs = 2'd1;
    if (RsD != '0 && RegWriteE && WriteRegE == RsD) wait_rs = MemtoRegE ? 2'd2 : 2'd1;
    wait_rt = '0;
    if (RtD != '0 && RegWriteM && MemtoRegM && WriteRegM == RtD) wait_rt = 2'd1;
    if (RtD != '0 && RegWriteE && WriteRegE == RtD) wait_rt = MemtoRegE ? 2'd2 : 2'd1;
    // bbt uses RtD as a bit index, so only Rs can create a dependency
    need = wait_rs;
    if (is_beq && wait_rt > need) need = wait_rt;
  end

  assign fwd_a = (RsD != '0) && RegWriteM && (WriteRegM == RsD);
  assign fwd_b = (RtD != '0) && RegWriteM && (WriteRegM == RtD) && !is_bbt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resolve   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    PCSrcD    = 1'b0;
    FlushD    = 1'b0;
    if (reset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_br) begin
            if (need == '0) begin
              resolve = 1'b1;
            end else begin
              StallF = 1'b1;
              StallD = 1'b1;
              FlushE = 1'b1;
              // The detecting IDLE cycle is itself the first stall, so only
              // need-1 WAIT cycles follow; cnt holds WAIT cycles left after this one.
              cnt_d   = need - 2'd2;
              state_d = (need == 2'd1) ? S_RES : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (cnt_q == '0) state_d = S_RES;
          else             cnt_d   = cnt_q - 2'd1;
        end
        S_RES: begin
          resolve = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (resolve) begin
        ForwardAD = fwd_a;
        ForwardBD = fwd_b;
        PCSrcD    = ConditionD;
        FlushD    = ConditionD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] BrCnt_q, TakenCnt_q, StallCycCnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      BrCnt_q       <= '0;
      TakenCnt_q    <= '0;
      StallCycCnt_q <= '0;
    end else begin
      if (resolve)               BrCnt_q       <= BrCnt_q + 32'd1;
      if (resolve && ConditionD) TakenCnt_q    <= TakenCnt_q + 32'd1;
      if (StallD)                StallCycCnt_q <= StallCycCnt_q + 32'd1;
    end
  end

  assign BrCnt       = BrCnt_q;
  assign TakenCnt    = TakenCnt_q;
  assign StallCycCnt = StallCycCnt_q;
`endif

endmodule
